// File: rtl/riffa_pkg.sv
// Shared types and constants for the RIFFA transmit path.
package riffa_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } tx_state_t;

  localparam int RIFFA_DW    = 64;
  localparam int RIFFA_LEN_W = 32;
  localparam int RIFFA_OFF_W = 31;

  // Number of 64-bit words needed to carry a given count of 32-bit pixels.
  function automatic logic [RIFFA_LEN_W-1:0] words_for(input logic [RIFFA_LEN_W-1:0] total);
    return {1'b0, total[RIFFA_LEN_W-1:1]} + {{(RIFFA_LEN_W-1){1'b0}}, total[0]};
  endfunction

endpackage

// File: rtl/tx_word_fifo.sv
// Synchronous first-word-fall-through FIFO holding packed 64-bit words.
module tx_word_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 512
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is left unreset; the read side never exposes an entry before it is written.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/riffa_tx_packer.sv
// RIFFA TX channel: packs 32-bit pixels into 64-bit words, buffers them and drives the TX handshake.
module riffa_tx_packer
  import riffa_pkg::*;
#(
  parameter int FIFO_DEPTH = 512,
  parameter int DATA_W     = RIFFA_DW
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic signed [RIFFA_LEN_W-1:0] out_rows,
  input  logic signed [RIFFA_LEN_W-1:0] out_cols,
  input  logic                          info_valid,
  input  logic [31:0]                   pixel_in,
  input  logic                          pixel_valid,
  output logic                          chnl_tx,
  input  logic                          chnl_tx_ack,
  output logic                          chnl_tx_last,
  output logic [RIFFA_LEN_W-1:0]        chnl_tx_len,
  output logic [RIFFA_OFF_W-1:0]        chnl_tx_off,
  output logic [DATA_W-1:0]             chnl_tx_data,
  output logic                          chnl_tx_data_valid,
  input  logic                          chnl_tx_data_ren,
  output logic                          busy,
  output logic                          overflow
);

  tx_state_t               state_q, state_d;
  logic [RIFFA_LEN_W-1:0]  len_q, len_d;
  logic [RIFFA_LEN_W-1:0]  words_q, words_d;
  logic [RIFFA_LEN_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [RIFFA_LEN_W-1:0]  word_cnt_q, word_cnt_d;
  logic                    half_q, half_d;
  logic [31:0]             lo_pix_q, lo_pix_d;
  logic                    pv_q, pv_d;
  logic [31:0]             pix_q, pix_d;
  logic                    overflow_q, overflow_d;

  logic                    arm_s;
  logic [RIFFA_LEN_W-1:0]  total_s;
  logic                    push_s;
  logic [DATA_W-1:0]       push_word_s;
  logic                    pop_s;
  logic [DATA_W-1:0]       head_s;
  logic                    fifo_full_s, fifo_empty_s;

  assign total_s = out_rows * out_cols;
  assign arm_s   = (state_q == IDLE) && info_valid &&
                   (out_rows > 32'sd0) && (out_cols > 32'sd0);
  assign pop_s   = (state_q == STREAM) && !fifo_empty_s && chnl_tx_data_ren;

  tx_word_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_s),
    .push_data (push_word_s),
    .pop       (pop_s),
    .head      (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Pixel staging, pair packing, counters and sticky overflow.
  always_comb begin
    len_d       = len_q;
    words_d     = words_q;
    pix_cnt_d   = pix_cnt_q;
    word_cnt_d  = word_cnt_q;
    half_d      = half_q;
    lo_pix_d    = lo_pix_q;
    overflow_d  = overflow_q;
    push_s      = 1'b0;
    push_word_s = '0;
    // Pixels are staged one cycle before packing, giving the 2-cycle arrival-to-valid latency.
    pv_d        = pixel_valid && ((state_q == REQ) || (state_q == STREAM));
    pix_d       = pv_d ? pixel_in : pix_q;

    if (arm_s) begin
      len_d      = total_s;
      words_d    = words_for(total_s);
      pix_cnt_d  = '0;
      word_cnt_d = '0;
      half_d     = 1'b0;
      overflow_d = 1'b0;
    end else begin
      if (pv_q) begin
        if (pix_cnt_q == len_q) begin
          overflow_d = 1'b1;
        end else begin
          pix_cnt_d = pix_cnt_q + 32'd1;
          if (half_q) begin
            push_s      = 1'b1;
            push_word_s = {pix_q, lo_pix_q};
            half_d      = 1'b0;
          end else if ((pix_cnt_q + 32'd1) == len_q) begin
            push_s      = 1'b1;
            push_word_s = {32'd0, pix_q};
          end else begin
            lo_pix_d = pix_q;
            half_d   = 1'b1;
          end
        end
      end else begin
        pix_cnt_d = pix_cnt_q;
      end
      if (push_s && fifo_full_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_d;
      end
      if (pop_s) begin
        word_cnt_d = word_cnt_q + 32'd1;
      end else begin
        word_cnt_d = word_cnt_q;
      end
    end
  end

  // Transfer sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (arm_s) state_d = REQ;
        else       state_d = IDLE;
      end
      REQ: begin
        if (chnl_tx_ack) state_d = STREAM;
        else             state_d = REQ;
      end
      STREAM: begin
        if ((words_q == 32'd0) || (pop_s && ((word_cnt_q + 32'd1) == words_q))) state_d = DONE;
        else                                                                 state_d = STREAM;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      words_q    <= '0;
      pix_cnt_q  <= '0;
      word_cnt_q <= '0;
      half_q     <= 1'b0;
      lo_pix_q   <= '0;
      pv_q       <= 1'b0;
      pix_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      words_q    <= words_d;
      pix_cnt_q  <= pix_cnt_d;
      word_cnt_q <= word_cnt_d;
      half_q     <= half_d;
      lo_pix_q   <= lo_pix_d;
      pv_q       <= pv_d;
      pix_q      <= pix_d;
      overflow_q <= overflow_d;
    end
  end

  assign chnl_tx            = (state_q == REQ) || (state_q == STREAM);
  assign busy               = chnl_tx;
  assign chnl_tx_last       = 1'b1;
  assign chnl_tx_off        = '0;
  assign chnl_tx_len        = len_q;
  assign chnl_tx_data_valid = (state_q == STREAM) && !fifo_empty_s;
  assign chnl_tx_data       = chnl_tx_data_valid ? head_s : '0;
  assign overflow           = overflow_q;

endmodule
